// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: widths, divider
// Signal codes and the DIVU sequencer state encoding.
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITERS = 32;
    localparam int unsigned SIG_W = 6;

    localparam logic [SIG_W-1:0] SIG_DIVU = 6'b011011;
    localparam logic [SIG_W-1:0] SIG_OUT  = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_OUT  = 3'd3,
        ST_WB   = 3'd4
    } divu_state_t;

endpackage

// File: rtl/divu_sequencer_if.sv
// Pipeline and divider connections of the DIVU sequencer; the slave side is
// the sequencer, the master side is the pipeline/divider environment.
interface divu_sequencer_if;
    import muldiv_pkg::*;

    logic                 start;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 mfhi;
    logic                 mflo;
    logic                 mthi;
    logic                 mtlo;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     div_a;
    logic [WIDTH-1:0]     div_b;
    logic                 div_load;
    logic [SIG_W-1:0]     div_signal;
    logic [2*WIDTH-1:0]   div_result;
    logic [WIDTH-1:0]     hilo_out;
    logic                 busy;
    logic                 stall;
    logic                 done;

    modport master (
        output start, op_a, op_b, mfhi, mflo, mthi, mtlo, wdata, div_result,
        input  div_a, div_b, div_load, div_signal, hilo_out, busy, stall, done
    );

    modport slave (
        input  start, op_a, op_b, mfhi, mflo, mthi, mtlo, wdata, div_result,
        output div_a, div_b, div_load, div_signal, hilo_out, busy, stall, done
    );

endinterface

// File: rtl/divu_sequencer_hilo_regs.sv
// HI/LO register pair with asynchronous active-low clear; the divide
// writeback takes priority over MTHI/MTLO.
module hilo_regs
    import muldiv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_we,
    input  logic [2*WIDTH-1:0] i_wb_data,
    input  logic               i_mthi_we,
    input  logic               i_mtlo_we,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_wb_we) begin
            r_hi <= i_wb_data[2*WIDTH-1:WIDTH];
            r_lo <= i_wb_data[WIDTH-1:0];
        end else begin
            if (i_mthi_we) r_hi <= i_wdata;
            if (i_mtlo_we) r_lo <= i_wdata;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/divu_sequencer.sv
// DIVU initiator: loads the iterative divider, counts its iterations,
// requests the result and commits {remainder, quotient} into HI/LO.
module divu_sequencer
    import muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    divu_sequencer_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    divu_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_div_a;
    logic [WIDTH-1:0]  r_div_b;
    logic              r_div_load;
    logic [SIG_W-1:0]  r_div_signal;
    logic              r_done;

    logic              w_idle;
    logic              w_req;
    logic              w_wb_we;
    logic              w_mthi_we;
    logic              w_mtlo_we;
    logic [WIDTH-1:0]  w_hi;
    logic [WIDTH-1:0]  w_lo;

    // Outputs are registered alongside the state so each code lines up with its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_div_a      <= '0;
            r_div_b      <= '0;
            r_div_load   <= 1'b0;
            r_div_signal <= '0;
            r_done       <= 1'b0;
        end else begin
            r_div_load <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_div_signal <= '0;
                    if (bus.start) begin
                        r_div_a    <= bus.op_a;
                        r_div_b    <= bus.op_b;
                        r_div_load <= 1'b1;
                        r_state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_cnt        <= '0;
                    r_div_signal <= SIG_DIVU;
                    r_state      <= ST_ITER;
                end
                ST_ITER: begin
                    if (r_cnt == CNT_LAST) begin
                        r_div_signal <= SIG_OUT;
                        r_state      <= ST_OUT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_OUT: begin
                    r_div_signal <= '0;
                    r_done       <= 1'b1;
                    r_state      <= ST_WB;
                end
                ST_WB: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_div_signal <= '0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_idle    = (r_state == ST_IDLE);
    assign w_req     = bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo;
    assign w_wb_we   = (r_state == ST_WB);
    // A start in the same cycle wins over MTHI/MTLO, which are then dropped.
    assign w_mthi_we = w_idle & ~bus.start & bus.mthi;
    assign w_mtlo_we = w_idle & ~bus.start & bus.mtlo;

    hilo_regs u_hilo (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_wb_we   (w_wb_we),
        .i_wb_data (bus.div_result),
        .i_mthi_we (w_mthi_we),
        .i_mtlo_we (w_mtlo_we),
        .i_wdata   (bus.wdata),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    assign bus.div_a      = r_div_a;
    assign bus.div_b      = r_div_b;
    assign bus.div_load   = r_div_load;
    assign bus.div_signal = r_div_signal;
    assign bus.done       = r_done;
    assign bus.busy       = ~w_idle;
    assign bus.stall      = ~w_idle & w_req;
    assign bus.hilo_out   = bus.mfhi ? w_hi : (bus.mflo ? w_lo : '0);

endmodule

// File: tb/tb_divu_sequencer.sv
// Scoreboard bench for divu_sequencer: stimulus queues expected reads and
// divide transactions, negedge monitors pop and compare them.
module tb_divu_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int unsigned t;
    } txn_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;

    logic [31:0] rd_q[$];
    txn_t        txn_q[$];

    txn_t        cur;
    logic        active;
    int unsigned n27;
    int unsigned n63;
    int unsigned t63;

    divu_sequencer_if bus ();

    divu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: presents {remainder, quotient} once OUT is requested.
    always @(posedge clk or negedge reset) begin
        if (!reset)
            bus.div_result <= '0;
        else if (bus.div_signal == SIG_OUT)
            bus.div_result <= (bus.div_b == 0) ? {bus.div_a, 32'hFFFF_FFFF}
                                               : {bus.div_a % bus.div_b, bus.div_a / bus.div_b};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected (got 1, required 0) at cycle %0d", name, cyc);
    endtask

    // Read monitor: a granted MFHI/MFLO consumes one expected value.
    always @(negedge clk) begin
        if (reset && (bus.mfhi || bus.mflo) && !bus.stall) begin
            if (rd_q.size() == 0) fail_event("read_unexpected");
            else chk("hilo_read", bus.hilo_out, rd_q.pop_front());
        end
    end

    // Transaction monitor: load timing, operand latch, Signal sequence, done timing.
    initial active = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            active = 1'b0;
        end else begin
            if (bus.div_load) begin
                if (txn_q.size() == 0) begin
                    fail_event("load_unexpected");
                end else begin
                    cur = txn_q.pop_front();
                    chk("load_cycle", cyc, cur.t);
                    chk("load_div_a", bus.div_a, cur.a);
                    chk("load_div_b", bus.div_b, cur.b);
                    active = 1'b1;
                    n27 = 0;
                    n63 = 0;
                    t63 = 0;
                end
            end
            if (active && bus.div_signal == SIG_DIVU) n27++;
            if (active && bus.div_signal == SIG_OUT) begin
                n63++;
                t63 = cyc;
            end
            if (bus.done) begin
                if (!active) begin
                    fail_event("done_unexpected");
                end else begin
                    chk("done_cycle", cyc, cur.t + 34);
                    chk("iter_cycles", n27, 32);
                    chk("out_cycles", n63, 1);
                    chk("out_cycle", t63, cur.t + 33);
                    chk("wb_div_a_stable", bus.div_a, cur.a);
                    active = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rd(input logic hi, input logic [31:0] exp);
        rd_q.push_back(exp);
        if (hi) bus.mfhi = 1'b1;
        else    bus.mflo = 1'b1;
        tick();
        bus.mfhi = 1'b0;
        bus.mflo = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int unsigned t);
        txn_t x;
        t = cyc + 1;
        x.a = a;
        x.b = b;
        x.t = t;
        txn_q.push_back(x);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
    endtask

    task automatic wait_idle(input int unsigned t, input string nm);
        int unsigned k = 0;
        do begin
            tick();
            k++;
        end while (bus.busy && k < 60);
        chk(nm, cyc, t + 35);
    endtask

    initial begin
        int unsigned t0, t1, t2, t3;
        int unsigned k;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0;
        bus.mfhi = 1'b0; bus.mflo = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.wdata = '0;

        repeat (3) tick();
        bus.mfhi = 1'b1;
        #1;
        chk("rst_div_a", bus.div_a, 0);
        chk("rst_div_b", bus.div_b, 0);
        chk("rst_div_load", bus.div_load, 0);
        chk("rst_div_signal", bus.div_signal, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hi", bus.hilo_out, 0);
        bus.mfhi = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rd(1'b1, 32'h0);
        rd(1'b0, 32'h0);

        // MTHI in IDLE, then MTHI+MTLO together, then MTHI alone
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.mthi = 1'b0;
        rd(1'b1, 32'hDEAD_BEEF);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hA5A5_0F0F;
        tick();
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        rd(1'b1, 32'hA5A5_0F0F);
        rd(1'b0, 32'hA5A5_0F0F);
        bus.mthi = 1'b1; bus.wdata = 32'h1111_1111;
        tick();
        bus.mthi = 1'b0;

        // 100/7 with a competing MTHI that must be dropped
        issue(32'd100, 32'd7, t0);
        bus.mthi = 1'b1; bus.wdata = 32'hCAFE_F00D;
        tick();
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mfhi = 1'b1;
        #1;
        chk("hi_kept_over_start_mthi", bus.hilo_out, 32'h1111_1111);
        chk("stall_mfhi_busy", bus.stall, 1);
        tick();
        bus.mfhi = 1'b0;
        rd_q.push_back(32'd14);
        bus.mflo = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (bus.stall && k < 60);
        chk("stall_release_cycle", cyc, t0 + 35);
        bus.mflo = 1'b0;

        // back-to-back 9/2 on the first IDLE cycle
        issue(32'd9, 32'd2, t1);
        #1;
        chk("b2b_no_stall", bus.stall, 0);
        tick();
        bus.start = 1'b0; bus.mfhi = 1'b1;
        #1;
        chk("hi_after_first", bus.hilo_out, 32'd2);
        bus.mfhi = 1'b0;
        wait_idle(t1, "b2b_latency");
        rd(1'b1, 32'd1);
        rd(1'b0, 32'd4);

        // divide by zero
        issue(32'd5, 32'd0, t2);
        tick();
        bus.start = 1'b0;
        wait_idle(t2, "dbz_latency");
        rd(1'b1, 32'd5);
        rd(1'b0, 32'hFFFF_FFFF);

        // reset during ITER with cnt==10
        issue(32'd50, 32'd3, t3);
        tick();
        bus.start = 1'b0;
        repeat (11) tick();
        chk("busy_before_reset", bus.busy, 1);
        reset = 1'b0;
        bus.mfhi = 1'b1;
        #1;
        chk("mid_rst_div_a", bus.div_a, 0);
        chk("mid_rst_div_b", bus.div_b, 0);
        chk("mid_rst_div_load", bus.div_load, 0);
        chk("mid_rst_div_signal", bus.div_signal, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_stall", bus.stall, 0);
        chk("mid_rst_hi", bus.hilo_out, 0);
        tick();
        tick();
        reset = 1'b1;
        bus.mfhi = 1'b0;
        repeat (40) tick();
        chk("idle_after_reset", bus.busy, 0);
        rd(1'b1, 32'h0);
        rd(1'b0, 32'h0);

        repeat (3) tick();
        chk("reads_drained", rd_q.size(), 0);
        chk("txns_drained", txn_q.size(), 0);
        chk("no_open_txn", active, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

endmodule
